div_unit: RTL and testbench
===========================

# div_unit

Parametrised, iterative restoring integer divider for the RV32M/RV64M execute stage, successor to the single-width, fire-and-forget divide unit. It adds a configurable operand width, a configurable number of quotient bits per cycle, and valid/ready handshakes on both request and response. It also adds a pipeline flush, single-cycle fast paths for divide-by-zero and signed overflow, and a result cache that answers DIV/REM pairs on identical operands without recomputing. It sits beside the multiplier in the execute stage and returns tagged results to writeback.

## Interface
- XLEN, 32: operand and result width. Legal values are 32 and 64.
- BITS_PER_CYCLE, 1: quotient bits resolved per iteration. Legal values are 1, 2 and 4; must divide XLEN.
- TAG_W, 5: width of the tag carried from request to response (destination register index).
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-high. One clock; reset is asynchronous and active-high.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  unit can accept a request.
- req_op_i  in  2  operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- req_a_i  in  XLEN  dividend (rs1).
- req_b_i  in  XLEN  divisor (rs2).
- req_tag_i  in  TAG_W  request tag.
- flush_i  in  1  kill any in-flight or pending operation.
- resp_valid_o  out  1  result valid.
- resp_ready_i  in  1  consumer accepts the result.
- resp_value_o  out  XLEN  quotient or remainder.
- resp_tag_o  out  TAG_W  tag of the result.

## Operation
- FSM states:
  - IDLE: req_ready_o = !flush_i.
  - BUSY: iterating; req_ready_o = 0.
  - DONE: resp_valid_o = 1; req_ready_o = 0.
- Accept condition: req_valid_i && req_ready_o. Op, operands and tag are captured.
- Classification at accept, first match wins:
  - **Divide by zero** (b == 0): quotient = all ones; remainder = a. Go to DONE.
  - **Signed overflow** (DIV/REM, a == 1<<(XLEN-1), b == all ones): quotient = a; remainder = 0. Go to DONE.
  - **Cache hit**: cache valid, and a, b and signedness (DIV/REM vs DIVU/REMU) match the cached entry. Return the cached quotient or remainder as the op selects. Go to DONE.
  - **Otherwise**: load |a| and |b| (magnitudes only for signed ops), clear the quotient, set iteration count N = XLEN/BITS_PER_CYCLE. Go to BUSY.
- BUSY iteration: each cycle performs BITS_PER_CYCLE chained restoring steps. Per step:
  - Compare against the remainder shifted left by one with the next dividend bit.
  - Subtract when not less than the divisor.
  - Shift the quotient bit in.
  - Decrement the count.
- Arithmetic uses an XLEN+1-bit remainder datapath. There is no truncation of intermediate values.
- BUSY exit, when the count reaches 0:
  - Apply signs. Quotient is negated iff the op is signed and sign(a) != sign(b). Remainder takes the sign of a.
  - Write signed quotient and remainder, a, b and signedness into the cache; set cache valid.
  - Register the selected result into resp_value_o.
  - Go to DONE.
- Fast paths never update the cache.
- DONE: hold resp_value_o and resp_tag_o stable while resp_ready_i = 0. When resp_valid_o && resp_ready_i, go to IDLE.
- Flush: flush_i = 1 in any state forces IDLE on the next edge.
  - Drops any BUSY computation or unaccepted DONE result.
  - Leaves the cache contents unchanged.
  - In the same cycle as req_valid_i: the request is not accepted.
  - In the same cycle as a DONE handshake: the result counts as consumed.
- Reset values:
  - State IDLE.
  - resp_valid_o = 0, resp_value_o = 0, resp_tag_o = 0.
  - req_ready_o = 1 after reset deasserts.
  - Cache valid = 0.
  - Reset asserted mid-operation aborts immediately.

## Timing
- Request handshake in cycle 0.
- Normal path: resp_valid_o is first high in cycle N+1, where N = XLEN/BITS_PER_CYCLE. Examples: 33 for 32/1; 9 for 32/4; 17 for 64/4.
- Fast path (div-zero, overflow, cache hit): resp_valid_o is high in cycle 1.
- Back-to-back: after a response handshake in cycle k, req_ready_o is high in cycle k+1. There is no same-cycle response/accept overlap.
- All outputs are registered, except req_ready_o, which is combinational from state and flush_i.
- No combinational path from req_*_i to resp_*_o.

## Test plan
All scenarios use XLEN=32, BITS_PER_CYCLE=1.
- **Signed divide**: DIV a=100, b=-7, tag 3 -> value 0xFFFFFFF2 (-14), tag 3, resp_valid_o first high in cycle 33. Then REM a=-100, b=7 -> 0xFFFFFFFE (-2); this is a cache miss because the operands differ.
- **Cache hit**: DIVU 1000/3 -> 333 in cycle 33. Immediately after, REMU 1000/3 -> 1 in cycle 1. Then REM 1000/3 -> normal latency; this is a miss because signedness differs.
- **Divide by zero**: DIVU 5/0 -> 0xFFFFFFFF in cycle 1; REM -9/0 -> 0xFFFFFFF7 in cycle 1.
- **Signed overflow**: DIV 0x80000000/-1 -> 0x80000000; REM of the same operands -> 0. Both in cycle 1.
- **Backpressure**: resp_ready_i held low for 10 cycles after a result -> resp_valid_o, value and tag stable; req_ready_o = 0 throughout. Release -> req_ready_o high the next cycle.
- **Flush and reset**:
  - Flush in cycle 10 of a DIV -> no response, IDLE next cycle.
  - A subsequent fresh DIV 7/2 -> 3.
  - rst_i asserted mid-BUSY -> resp_valid_o = 0 immediately.
  - A repeat of the earlier request after reset -> cache miss, full latency.

Source files
------------

// File: rtl/div_if.sv
// Request/response bundle for div_unit.
//   req_valid_i/req_ready_o : request handshake carrying req_op_i,
//                             req_a_i, req_b_i and req_tag_i
//   flush_i                 : kill any in-flight or pending operation
//   resp_valid_o/resp_ready_i : response handshake carrying
//                             resp_value_o and resp_tag_o
// The master drives requests and consumes responses. The slave is the divider.
interface div_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
);
  logic             req_valid_i;
  logic             req_ready_o;
  logic [1:0]       req_op_i;
  logic [XLEN-1:0]  req_a_i;
  logic [XLEN-1:0]  req_b_i;
  logic [TAG_W-1:0] req_tag_i;
  logic             flush_i;
  logic             resp_valid_o;
  logic             resp_ready_i;
  logic [XLEN-1:0]  resp_value_o;
  logic [TAG_W-1:0] resp_tag_o;

  modport master (
    output req_valid_i, req_op_i, req_a_i, req_b_i, req_tag_i, flush_i,
           resp_ready_i,
    input  req_ready_o, resp_valid_o, resp_value_o, resp_tag_o
  );

  modport slave (
    input  req_valid_i, req_op_i, req_a_i, req_b_i, req_tag_i, flush_i,
           resp_ready_i,
    output req_ready_o, resp_valid_o, resp_value_o, resp_tag_o
  );
endinterface

// File: rtl/div_unit.sv
// Iterative restoring integer divider for RV32M/RV64M (DIV/DIVU/REM/REMU).
//   clk_i : clock
//   rst_i : asynchronous active-high reset
//   bus   : div_if slave port (request handshake, flush, response handshake)
// Divide-by-zero, signed overflow and repeats of the last computed operand
// pair answer in one cycle. All other requests take XLEN/BITS_PER_CYCLE
// iterations. Each iteration resolves BITS_PER_CYCLE quotient bits.
module div_unit #(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1,
  parameter int TAG_W          = 5
) (
  input  logic clk_i,
  input  logic rst_i,
  div_if.slave bus
);
  localparam int N  = XLEN / BITS_PER_CYCLE;
  localparam int CW = $clog2(N + 1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t           state_reg, state_next;
  logic [CW-1:0]    count_reg;
  logic [XLEN-1:0]  rem_reg;
  logic [XLEN-1:0]  dq_reg;     // dividend shifts out at the top, quotient enters at the bottom
  logic [XLEN-1:0]  div_reg;
  logic             neg_q_reg, neg_r_reg, rem_sel_reg, sgn_reg;
  logic [XLEN-1:0]  a_reg, b_reg;
  logic             cache_valid_reg, cache_sgn_reg;
  logic [XLEN-1:0]  cache_a_reg, cache_b_reg, cache_q_reg, cache_r_reg;
  logic             resp_valid_reg;
  logic [XLEN-1:0]  resp_value_reg;
  logic [TAG_W-1:0] resp_tag_reg;
  logic             req_ready, accept;

  // Request classification
  logic            in_sgn, in_rem, a_neg, b_neg, div_zero, ovf, hit, fast;
  logic [XLEN-1:0] fast_value;

  assign in_sgn   = !bus.req_op_i[0];
  assign in_rem   = bus.req_op_i[1];
  assign a_neg    = in_sgn && bus.req_a_i[XLEN-1];
  assign b_neg    = in_sgn && bus.req_b_i[XLEN-1];
  assign div_zero = (bus.req_b_i == '0);
  assign ovf      = in_sgn && (bus.req_a_i == MIN_NEG) && (bus.req_b_i == '1);
  assign hit      = cache_valid_reg && (bus.req_a_i == cache_a_reg) &&
                    (bus.req_b_i == cache_b_reg) && (in_sgn == cache_sgn_reg);
  assign fast     = div_zero || ovf || hit;

  always_comb begin
    fast_value = '0;
    if (div_zero)  fast_value = in_rem ? bus.req_a_i : '1;
    else if (ovf)  fast_value = in_rem ? '0 : bus.req_a_i;
    else           fast_value = in_rem ? cache_r_reg : cache_q_reg;
  end

  // Chained restoring steps. Because rem < divisor, the shifted value stays
  // below 2*divisor. The borrow out of the (XLEN+1)-bit subtract is
  // therefore the exact "less than divisor" test.
  logic [XLEN-1:0] rem_c [BITS_PER_CYCLE+1];
  logic [XLEN-1:0] dq_c  [BITS_PER_CYCLE+1];
  assign rem_c[0] = rem_reg;
  assign dq_c[0]  = dq_reg;

  genvar gi;
  generate
    for (gi = 0; gi < BITS_PER_CYCLE; gi++) begin : g_step
      logic [XLEN:0] shifted, diff;
      logic          ge;
      assign shifted      = {rem_c[gi], dq_c[gi][XLEN-1]};
      assign diff         = shifted - {1'b0, div_reg};
      assign ge           = !diff[XLEN];
      assign rem_c[gi+1]  = ge ? diff[XLEN-1:0] : shifted[XLEN-1:0];
      assign dq_c[gi+1]   = {dq_c[gi][XLEN-2:0], ge};
    end
  endgenerate

  logic [XLEN-1:0] q_fin, r_fin;
  assign q_fin = neg_q_reg ? -dq_c[BITS_PER_CYCLE]  : dq_c[BITS_PER_CYCLE];
  assign r_fin = neg_r_reg ? -rem_c[BITS_PER_CYCLE] : rem_c[BITS_PER_CYCLE];

  // FSM next state and ready
  always_comb begin
    state_next = state_reg;
    req_ready  = 1'b0;
    case (state_reg)
      IDLE: begin
        req_ready = !bus.flush_i;
        if (bus.req_valid_i && req_ready) state_next = fast ? DONE : BUSY;
      end
      BUSY: if (count_reg == CW'(1)) state_next = DONE;
      DONE: if (bus.resp_ready_i) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (bus.flush_i) state_next = IDLE;
  end

  assign accept = bus.req_valid_i && req_ready;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_reg       <= '0;
      rem_reg         <= '0;
      dq_reg          <= '0;
      div_reg         <= '0;
      neg_q_reg       <= 1'b0;
      neg_r_reg       <= 1'b0;
      rem_sel_reg     <= 1'b0;
      sgn_reg         <= 1'b0;
      a_reg           <= '0;
      b_reg           <= '0;
      cache_valid_reg <= 1'b0;
      cache_sgn_reg   <= 1'b0;
      cache_a_reg     <= '0;
      cache_b_reg     <= '0;
      cache_q_reg     <= '0;
      cache_r_reg     <= '0;
      resp_valid_reg  <= 1'b0;
      resp_value_reg  <= '0;
      resp_tag_reg    <= '0;
    end else begin
      resp_valid_reg <= (state_next == DONE);
      if (accept) begin
        resp_tag_reg <= bus.req_tag_i;
        rem_sel_reg  <= in_rem;
        sgn_reg      <= in_sgn;
        a_reg        <= bus.req_a_i;
        b_reg        <= bus.req_b_i;
        neg_q_reg    <= in_sgn && (bus.req_a_i[XLEN-1] ^ bus.req_b_i[XLEN-1]);
        neg_r_reg    <= a_neg;
        rem_reg      <= '0;
        dq_reg       <= a_neg ? -bus.req_a_i : bus.req_a_i;
        div_reg      <= b_neg ? -bus.req_b_i : bus.req_b_i;
        count_reg    <= CW'(N);
        if (fast) resp_value_reg <= fast_value;
      end else if (state_reg == BUSY) begin
        rem_reg   <= rem_c[BITS_PER_CYCLE];
        dq_reg    <= dq_c[BITS_PER_CYCLE];
        count_reg <= count_reg - CW'(1);
        // A flush in the final cycle leaves state_next at IDLE and the cache untouched.
        if (state_next == DONE) begin
          resp_value_reg  <= rem_sel_reg ? r_fin : q_fin;
          cache_valid_reg <= 1'b1;
          cache_sgn_reg   <= sgn_reg;
          cache_a_reg     <= a_reg;
          cache_b_reg     <= b_reg;
          cache_q_reg     <= q_fin;
          cache_r_reg     <= r_fin;
        end
      end
    end
  end

  assign bus.req_ready_o  = req_ready;
  assign bus.resp_valid_o = resp_valid_reg;
  assign bus.resp_value_o = resp_value_reg;
  assign bus.resp_tag_o   = resp_tag_reg;
endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit (XLEN=32, BITS_PER_CYCLE=1): directed
// scenarios with literal expectations, then randomized requests checked
// against an arithmetic reference model with its own one-entry cache.
module tb_div_unit;
  localparam int LAT = 33;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  div_if #(.XLEN(32), .TAG_W(5)) bus ();
  div_unit #(.XLEN(32), .BITS_PER_CYCLE(1), .TAG_W(5)) dut (
    .clk_i(clk), .rst_i(rst), .bus(bus.slave)
  );

  int errors = 0;
  int checks = 0;

  // expected response seen by the compare process
  logic        exp_pending = 1'b0;
  logic [31:0] exp_value   = '0;
  logic [4:0]  exp_tag     = '0;

  // model cache
  logic        mc_valid = 1'b0;
  logic        mc_sgn   = 1'b0;
  logic [31:0] mc_a = '0, mc_b = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [31:0] model_res(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    logic sgn, rem;
    sgn = !op[0];
    rem = op[1];
    sa = a;
    sb = b;
    if (b == 0) return rem ? a : 32'hFFFF_FFFF;
    if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return rem ? 32'h0 : a;
    if (sgn) return rem ? 32'(sa % sb) : 32'(sa / sb);
    return rem ? a % b : a / b;
  endfunction

  function automatic logic model_fast(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic sgn;
    sgn = !op[0];
    return (b == 0) || (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ||
           (mc_valid && a == mc_a && b == mc_b && sgn == mc_sgn);
  endfunction

  // Compare process: every cycle the response is valid it must be expected
  // and match the model, and no request may be offered.
  always @(negedge clk) begin
    if (bus.resp_valid_o) begin
      chk("resp_expected", {63'd0, exp_pending}, 64'd1);
      chk("resp_value", {32'd0, bus.resp_value_o}, {32'd0, exp_value});
      chk("resp_tag", {59'd0, bus.resp_tag_o}, {59'd0, exp_tag});
      chk("ready_low_in_done", {63'd0, bus.req_ready_o}, 64'd0);
    end
  end

  task automatic drive_req(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] tag);
    bus.req_valid_i = 1'b1;
    bus.req_op_i    = op;
    bus.req_a_i     = a;
    bus.req_b_i     = b;
    bus.req_tag_i   = tag;
    @(posedge clk);
    #1;
    bus.req_valid_i = 1'b0;
    bus.req_a_i     = $urandom;
    bus.req_b_i     = $urandom;
    bus.req_tag_i   = 5'($urandom);
  endtask

  task automatic run(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [4:0] tag, input int hold, input logic [31:0] want, input int want_lat);
    int lat;
    logic was_fast;
    logic [31:0] v0;
    was_fast = model_fast(op, a, b);
    @(negedge clk);
    chk("req_ready_idle", {63'd0, bus.req_ready_o}, 64'd1);
    exp_value   = want;
    exp_tag     = tag;
    exp_pending = 1'b1;
    drive_req(op, a, b, tag);
    lat = 0;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (bus.resp_valid_o) begin
        lat = c;
        break;
      end
    end
    chk("latency", 64'(lat), 64'(want_lat));
    v0 = bus.resp_value_o;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_valid", {63'd0, bus.resp_valid_o}, 64'd1);
      chk("hold_value", {32'd0, bus.resp_value_o}, {32'd0, v0});
    end
    bus.resp_ready_i = 1'b1;
    @(posedge clk);
    #1;
    bus.resp_ready_i = 1'b0;
    exp_pending = 1'b0;
    @(negedge clk);
    chk("b2b_ready", {62'd0, bus.req_ready_o, bus.resp_valid_o}, 64'd2);
    if (!was_fast) begin
      mc_valid = 1'b1;
      mc_sgn   = !op[0];
      mc_a     = a;
      mc_b     = b;
    end
    $display("op=%0d a=%08h b=%08h tag=%0d -> value=%08h lat=%0d hold=%0d", op, a, b, tag, v0, lat, hold);
  endtask

  function automatic logic [31:0] rand_opnd();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 20));
      4: return -32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] ra, rb, rw;
    logic [1:0]  rop;
    bus.req_valid_i  = 1'b0;
    bus.req_op_i     = 2'd0;
    bus.req_a_i      = '0;
    bus.req_b_i      = '0;
    bus.req_tag_i    = '0;
    bus.flush_i      = 1'b0;
    bus.resp_ready_i = 1'b0;

    // model pins
    chk("pin_div", {32'd0, model_res(2'b00, 32'd100, -32'd7)}, 64'hFFFF_FFF2);
    chk("pin_rem", {32'd0, model_res(2'b10, -32'd100, 32'd7)}, 64'hFFFF_FFFE);
    chk("pin_remu", {32'd0, model_res(2'b11, 32'd1000, 32'd3)}, 64'd1);
    chk("pin_ovf", {32'd0, model_res(2'b00, 32'h8000_0000, 32'hFFFF_FFFF)}, 64'h8000_0000);

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_valid", {63'd0, bus.resp_valid_o}, 64'd0);
    chk("rst_value", {32'd0, bus.resp_value_o}, 64'd0);
    chk("rst_tag", {59'd0, bus.resp_tag_o}, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", {63'd0, bus.req_ready_o}, 64'd1);

    // signed divide, cache, div-by-zero, overflow
    run(2'b00, 32'd100, -32'd7, 5'd3, 0, 32'hFFFF_FFF2, LAT);
    run(2'b10, -32'd100, 32'd7, 5'd4, 0, 32'hFFFF_FFFE, LAT);
    run(2'b01, 32'd1000, 32'd3, 5'd5, 0, 32'd333, LAT);
    run(2'b11, 32'd1000, 32'd3, 5'd6, 0, 32'd1, 1);
    run(2'b10, 32'd1000, 32'd3, 5'd7, 0, 32'd1, LAT);
    run(2'b01, 32'd5, 32'd0, 5'd8, 0, 32'hFFFF_FFFF, 1);
    run(2'b10, -32'd9, 32'd0, 5'd9, 0, 32'hFFFF_FFF7, 1);
    run(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 0, 32'h8000_0000, 1);
    run(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 0, 32'h0, 1);

    // backpressure
    run(2'b01, 32'd1000, 32'd7, 5'd12, 10, 32'd142, LAT);

    // flush in cycle 10 of a DIV
    @(negedge clk);
    drive_req(2'b00, 32'd12345, 32'd67, 5'd13);
    repeat (10) @(negedge clk);
    bus.flush_i = 1'b1;
    #1;
    chk("flush_busy_ready", {63'd0, bus.req_ready_o}, 64'd0);
    @(posedge clk);
    #1;
    bus.flush_i = 1'b0;
    @(negedge clk);
    chk("flush_idle", {62'd0, bus.req_ready_o, bus.resp_valid_o}, 64'd2);
    repeat (40) @(negedge clk);

    // flush with a request in IDLE: not accepted
    bus.flush_i = 1'b1;
    bus.req_valid_i = 1'b1;
    bus.req_op_i = 2'b01;
    bus.req_a_i = 32'd1;
    bus.req_b_i = 32'd0;
    #1;
    chk("flush_ready_low", {63'd0, bus.req_ready_o}, 64'd0);
    @(posedge clk);
    #1;
    bus.flush_i = 1'b0;
    bus.req_valid_i = 1'b0;
    @(negedge clk);
    chk("flush_no_accept", {62'd0, bus.req_ready_o, bus.resp_valid_o}, 64'd2);

    run(2'b00, 32'd7, 32'd2, 5'd14, 0, 32'd3, LAT);

    // reset mid-BUSY: aborts at once and clears the cache
    @(negedge clk);
    drive_req(2'b01, 32'd9, 32'd4, 5'd15);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_mid_abort", {62'd0, bus.req_ready_o, bus.resp_valid_o}, 64'd2);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    mc_valid = 1'b0;
    run(2'b10, 32'd7, 32'd2, 5'd16, 0, 32'd1, LAT);

    // randomized, with operand reuse to exercise the cache
    ra = 32'd1;
    rb = 32'd1;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 2) != 0) begin
        ra = rand_opnd();
        rb = rand_opnd();
      end
      rop = 2'($urandom_range(0, 3));
      rw  = model_res(rop, ra, rb);
      run(rop, ra, rb, 5'($urandom), $urandom_range(0, 3), rw,
          model_fast(rop, ra, rb) ? 1 : LAT);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
